// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
// Read-side handshake between the UART transmit byte FIFO and the
// serializer that drains it.
//
//   fifo_empty    FIFO -> serializer  FIFO holds no words
//   fifo_rd_en    serializer -> FIFO  one-cycle pop strobe
//   fifo_rd_data  FIFO -> serializer  popped word, valid the cycle after a pop
//
// master : the serializer (consumer)
// slave  : the FIFO (producer)
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  modport master (
    input  fifo_empty,
    output fifo_rd_en,
    input  fifo_rd_data
  );

  modport slave (
    output fifo_empty,
    input  fifo_rd_en,
    output fifo_rd_data
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Pops one word at a time from the transmit FIFO and shifts it out on the
// serial line as: start bit, DATA_WIDTH data bits LSB first, optional parity
// bit, STOP_BITS stop bits. The bit period is a runtime divisor (clocks per
// bit, clamped to a minimum of 2) latched once per frame.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   tx_en        permits starting new frames; a running frame always finishes
//   baud_div     clocks per bit, latched when the frame is fetched
//   parity_en    insert a parity bit, latched when the frame is fetched
//   parity_odd   1 = odd parity, 0 = even, latched when the frame is fetched
//   fifo         FIFO read handshake (master side)
//   tx           registered serial output, idles high
//   busy         high whenever the FSM is not IDLE
//   frame_done   one-cycle pulse on the final cycle of the last stop bit
//
// STOP_BITS must be 1 or 2.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  uart_tx_serializer_if.master fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int DATA_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int STOP_CNT_W = 2;

  localparam logic [DIV_WIDTH-1:0]  DIV_MIN   = DIV_WIDTH'(32'd2);
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE   = DIV_WIDTH'(32'd1);
  localparam logic [DIV_WIDTH-1:0]  DIV_ZERO  = DIV_WIDTH'(32'd0);
  localparam logic [DATA_CNT_W-1:0] DATA_LAST = DATA_CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_CNT_W-1:0] DATA_ONE  = DATA_CNT_W'(32'd1);
  localparam logic [DATA_CNT_W-1:0] DATA_ZERO = DATA_CNT_W'(32'd0);
  localparam logic [STOP_CNT_W-1:0] STOP_LAST = STOP_CNT_W'(STOP_BITS - 1);
  localparam logic [STOP_CNT_W-1:0] STOP_ONE  = STOP_CNT_W'(32'd1);
  localparam logic [STOP_CNT_W-1:0] STOP_ZERO = STOP_CNT_W'(32'd0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(
    input logic [DATA_WIDTH-1:0] data,
    input logic                  odd
  );
    calc_parity = (^data) ^ odd;
  endfunction

  state_t                  state_r,      state_s;
  logic [DIV_WIDTH-1:0]    bit_cnt_r,    bit_cnt_s;
  logic [DATA_CNT_W-1:0]   data_cnt_r,   data_cnt_s;
  logic [STOP_CNT_W-1:0]   stop_cnt_r,   stop_cnt_s;
  logic [DATA_WIDTH-1:0]   shift_r,      shift_s;
  logic [DIV_WIDTH-1:0]    eff_div_r,    eff_div_s;
  logic                    parity_en_r,  parity_en_s;
  logic                    parity_bit_r, parity_bit_s;
  logic                    tx_r,         tx_s;
  logic                    busy_r,       busy_s;
  logic                    frame_done_r, frame_done_s;
  logic                    rd_en_s;
  logic                    bit_end_s;

  // Last cycle of the current bit period.
  assign bit_end_s = (bit_cnt_r == (eff_div_r - DIV_ONE));

  // The pop strobe must be combinational so the pop is a single cycle. It is
  // also held low while reset is asserted so no word is consumed and lost
  // while the FSM is being held in IDLE.
  assign fifo.fifo_rd_en = rd_en_s;

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    data_cnt_s   = data_cnt_r;
    stop_cnt_s   = stop_cnt_r;
    shift_s      = shift_r;
    eff_div_s    = eff_div_r;
    parity_en_s  = parity_en_r;
    parity_bit_s = parity_bit_r;
    tx_s         = tx_r;
    rd_en_s      = 1'b0;

    case (state_r)
      IDLE: begin
        tx_s    = 1'b1;
        rd_en_s = rst_n & tx_en & ~fifo.fifo_empty;
        if (rd_en_s) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end

      // The FIFO's registered read data is valid in this cycle: capture the
      // word and every per-frame setting together so mid-frame input changes
      // only reach the next frame.
      FETCH: begin
        state_s      = START;
        shift_s      = fifo.fifo_rd_data;
        parity_en_s  = parity_en;
        parity_bit_s = calc_parity(fifo.fifo_rd_data, parity_odd);
        bit_cnt_s    = DIV_ZERO;
        data_cnt_s   = DATA_ZERO;
        stop_cnt_s   = STOP_ZERO;
        tx_s         = 1'b0;
        if (baud_div < DIV_MIN) begin
          eff_div_s = DIV_MIN;
        end else begin
          eff_div_s = baud_div;
        end
      end

      START: begin
        if (bit_end_s) begin
          bit_cnt_s = DIV_ZERO;
          state_s   = DATA;
          tx_s      = shift_r[0];
        end else begin
          bit_cnt_s = bit_cnt_r + DIV_ONE;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          bit_cnt_s = DIV_ZERO;
          if (data_cnt_r == DATA_LAST) begin
            if (parity_en_r) begin
              state_s = PARITY;
              tx_s    = parity_bit_r;
            end else begin
              state_s = STOP;
              tx_s    = 1'b1;
            end
          end else begin
            // Shift right so the next data bit always sits in bit 0.
            data_cnt_s = data_cnt_r + DATA_ONE;
            shift_s    = shift_r >> 1;
            tx_s       = shift_s[0];
          end
        end else begin
          bit_cnt_s = bit_cnt_r + DIV_ONE;
        end
      end

      PARITY: begin
        if (bit_end_s) begin
          bit_cnt_s = DIV_ZERO;
          state_s   = STOP;
          tx_s      = 1'b1;
        end else begin
          bit_cnt_s = bit_cnt_r + DIV_ONE;
        end
      end

      STOP: begin
        tx_s = 1'b1;
        if (bit_end_s) begin
          bit_cnt_s = DIV_ZERO;
          if (stop_cnt_r == STOP_LAST) begin
            stop_cnt_s = STOP_ZERO;
            state_s    = IDLE;
          end else begin
            stop_cnt_s = stop_cnt_r + STOP_ONE;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + DIV_ONE;
        end
      end

      default: begin
        state_s    = IDLE;
        bit_cnt_s  = DIV_ZERO;
        data_cnt_s = DATA_ZERO;
        stop_cnt_s = STOP_ZERO;
        tx_s       = 1'b1;
      end
    endcase

    // Outputs are registered from next-state values so that they line up
    // with the state they describe.
    busy_s       = (state_s != IDLE);
    frame_done_s = (state_s == STOP) && (stop_cnt_s == STOP_LAST) &&
                   (bit_cnt_s == (eff_div_s - DIV_ONE));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bit timing counters and per-frame datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r    <= DIV_ZERO;
      data_cnt_r   <= DATA_ZERO;
      stop_cnt_r   <= STOP_ZERO;
      shift_r      <= {DATA_WIDTH{1'b0}};
      eff_div_r    <= DIV_ZERO;
      parity_en_r  <= 1'b0;
      parity_bit_r <= 1'b0;
    end else begin
      bit_cnt_r    <= bit_cnt_s;
      data_cnt_r   <= data_cnt_s;
      stop_cnt_r   <= stop_cnt_s;
      shift_r      <= shift_s;
      eff_div_r    <= eff_div_s;
      parity_en_r  <= parity_en_s;
      parity_bit_r <= parity_bit_s;
    end
  end

  // Registered outputs; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      tx_r         <= tx_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
// Self-checking bench: a small FIFO model feeds the serializer, and every
// frame is compared cycle by cycle against a line waveform built from the
// frame rules (start, data LSB first, parity from a count of ones, stops).
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int STOP_N = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        tx;
  logic        busy;
  logic        frame_done;

  uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_serializer #(
    .DATA_WIDTH(8),
    .STOP_BITS (STOP_N),
    .DIV_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .fifo      (bus),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model with a registered read port.
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= mem[rd_ptr];
      rd_ptr           <= rd_ptr + 4'd1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  // Event monitors.
  int pop_cnt       = 0;
  int done_cnt      = 0;
  int underflow_cnt = 0;
  int busy_run      = 0;
  int last_busy_run = 0;

  always @(posedge clk) begin
    if (bus.fifo_rd_en) pop_cnt <= pop_cnt + 1;
    if (bus.fifo_rd_en && bus.fifo_empty) underflow_cnt <= underflow_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (busy) begin
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) last_busy_run <= busy_run;
      busy_run <= 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_done = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Waits (bounded) for the start bit, then checks the whole frame on the
  // line. Returns with the time aligned to the last cycle of the last stop
  // bit; gap is the number of idle-high cycles seen before the start bit.
  task automatic expect_frame(input logic [7:0] d, input int div,
                              input bit pen, input bit podd, output int gap);
    bit bits[$];
    int eff;
    int ones;
    bit timed_out;
    eff  = (div < 2) ? 2 : div;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pen) bits.push_back(((ones % 2) == 1) != podd);
    for (int i = 0; i < STOP_N; i++) bits.push_back(1'b1);

    gap       = 0;
    timed_out = 1'b0;
    @(negedge clk);
    while (tx !== 1'b0 && !timed_out) begin
      gap++;
      if (gap > 300) timed_out = 1'b1;
      else @(negedge clk);
    end
    if (timed_out) begin
      check_eq("start_wait", int'(tx), 0);
    end else begin
      for (int b = 0; b < bits.size(); b++) begin
        for (int c = 0; c < eff; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          check_eq($sformatf("tx_d%02h_b%0d", d, b), int'(tx), int'(bits[b]));
          check_eq("busy_in_frame", int'(busy), 1);
          check_eq("frame_done", int'(frame_done),
                   int'((b == bits.size() - 1) && (c == eff - 1)));
        end
      end
      exp_done++;
    end
  endtask

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          gap;
  int          p0;
  int          w;
  logic [7:0]  rd;
  int          rdiv;
  bit          rpen;
  bit          rpodd;

  initial begin
    rst_n      = 1'b0;
    tx_en      = 1'b1;
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    push(8'h55);
    repeat (3) @(negedge clk);

    // Reset state: no pop even with data waiting and tx_en high.
    check_eq("rst_tx", int'(tx), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    check_eq("rst_rd_en", int'(bus.fifo_rd_en), 0);
    check_eq("rst_pops", pop_cnt, 0);
    rst_n = 1'b1;

    // Single frame, divisor 4, no parity.
    expect_frame(8'h55, 4, 1'b0, 1'b0, gap);
    repeat (2) @(negedge clk);
    check_eq("busy_len", last_busy_run, 1 + (1 + 8 + STOP_N) * 4);
    check_eq("single_pops", pop_cnt, 1);

    // Even then odd parity.
    baud_div  = 16'd3;
    parity_en = 1'b1;
    push(8'h07);
    expect_frame(8'h07, 3, 1'b1, 1'b0, gap);
    parity_odd = 1'b1;
    push(8'h07);
    expect_frame(8'h07, 3, 1'b1, 1'b1, gap);

    // Divisor clamp.
    parity_en = 1'b0;
    baud_div  = 16'd0;
    push(8'hC4);
    expect_frame(8'hC4, 0, 1'b0, 1'b0, gap);
    baud_div = 16'd1;
    push(8'h9E);
    expect_frame(8'h9E, 1, 1'b0, 1'b0, gap);

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      rd         = 8'($urandom);
      rdiv       = int'($urandom_range(0, 6));
      rpen       = 1'($urandom);
      rpodd      = 1'($urandom);
      baud_div   = 16'(rdiv);
      parity_en  = rpen;
      parity_odd = rpodd;
      push(rd);
      expect_frame(rd, rdiv, rpen, rpodd, gap);
    end

    // Back-to-back frames: exactly two idle-high cycles between them.
    baud_div  = 16'd5;
    parity_en = 1'b0;
    push(8'hA3);
    push(8'h3C);
    expect_frame(8'hA3, 5, 1'b0, 1'b0, gap);
    expect_frame(8'h3C, 5, 1'b0, 1'b0, gap);
    check_eq("b2b_gap", gap, 2);

    // Settings changed mid-frame only reach the next frame.
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    push(8'h5A);
    push(8'hE1);
    fork
      begin
        expect_frame(8'h5A, 4, 1'b0, 1'b0, gap);
        expect_frame(8'hE1, 8, 1'b1, 1'b1, gap);
      end
      begin
        repeat (12) @(negedge clk);
        baud_div   = 16'd8;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
      end
    join
    check_eq("chg_gap", gap, 2);

    // Empty FIFO: no pop, line idle.
    baud_div  = 16'd4;
    parity_en = 1'b0;
    @(negedge clk);
    p0 = pop_cnt;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check_eq("empty_tx", int'(tx), 1);
      check_eq("empty_rd_en", int'(bus.fifo_rd_en), 0);
    end
    check_eq("empty_pops", pop_cnt - p0, 0);

    // tx_en low with data waiting: no pop until enabled.
    tx_en = 1'b0;
    push(8'h81);
    repeat (50) @(negedge clk);
    check_eq("dis_pops", pop_cnt - p0, 0);
    check_eq("dis_tx", int'(tx), 1);
    check_eq("dis_busy", int'(busy), 0);
    tx_en = 1'b1;
    expect_frame(8'h81, 4, 1'b0, 1'b0, gap);

    // tx_en dropped mid-frame: frame completes, no further pops.
    push(8'h36);
    push(8'hC9);
    fork
      expect_frame(8'h36, 4, 1'b0, 1'b0, gap);
      begin
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    p0 = pop_cnt;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      check_eq("txen_off_tx", int'(tx), 1);
    end
    check_eq("txen_off_pops", pop_cnt - p0, 0);
    tx_en = 1'b1;
    expect_frame(8'hC9, 4, 1'b0, 1'b0, gap);

    // Reset during data bit 3: line returns idle immediately.
    push(8'h63);
    w = 0;
    @(negedge clk);
    while (tx !== 1'b0 && w < 20) begin
      w++;
      @(negedge clk);
    end
    check_eq("rst_test_start", int'(tx), 0);
    repeat (17) @(negedge clk);
    check_eq("pre_rst_bit3", int'(tx), 0);
    check_eq("pre_rst_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", int'(tx), 1);
    check_eq("async_rst_busy", int'(busy), 0);
    check_eq("async_rst_rd_en", int'(bus.fifo_rd_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(8'hF0);
    expect_frame(8'hF0, 4, 1'b0, 1'b0, gap);

    // Totals.
    repeat (3) @(negedge clk);
    check_eq("done_pulses", done_cnt, exp_done);
    check_eq("underflow", underflow_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
